attribute_update_scheduler: RTL and testbench

- Owns the five 14-bit player attributes (HP, ATK, DEF, GOLD, EXP) and the five-slot energy gauge shown by the attribute table drawer.
- Drives the drawer's ValueArr, EnergyDone and EnergyProgress inputs.
- Arbitrates read-modify-write requests from game-logic requesters (combat, item pickup, shop) round-robin, applies saturating arithmetic, and advances the energy gauge on FRAME_CLK ticks.

---
 rtl/attribute_update_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_attribute_update_scheduler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/attribute_update_scheduler.sv
// Attribute table owner: round-robin read-modify-write of five saturating 14-bit
// attributes, plus a five-slot energy gauge advanced by a synchronized frame strobe.
module attribute_update_scheduler #(
    parameter int          NUM_REQ         = 3,
    parameter logic [13:0] VALUE_MAX       = 14'd9999,
    parameter logic [69:0] INIT_VALUES     = {14'd0, 14'd0, 14'd10, 14'd10, 14'd1000},
    parameter int          FRAMES_PER_STEP = 8
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  FRAME_CLK,
    input  logic [NUM_REQ-1:0]    REQ_VALID,
    input  logic [NUM_REQ*3-1:0]  REQ_ATTR,
    input  logic [NUM_REQ*2-1:0]  REQ_OP,
    input  logic [NUM_REQ*14-1:0] REQ_OPERAND,
    output logic [NUM_REQ-1:0]    REQ_ACK,
    output logic                  REQ_FLAG,
    input  logic                  ENERGY_USE,
    output logic                  ENERGY_USE_OK,
    output logic [69:0]           ValueArr,
    output logic [4:0]            EnergyDone,
    output logic [3:0]            EnergyProgress
);

    // state  | meaning
    // S_IDLE | waiting for a request; latches the round-robin winner
    // S_EXEC | computes and writes the target attribute
    // S_DONE | ACK/FLAG visible; advances the round-robin pointer
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DIV_W = $clog2(FRAMES_PER_STEP + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAMES_PER_STEP - 1);
    localparam logic [14:0] MAX15 = {1'b0, VALUE_MAX};
    localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_SET = 2'd2;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d, win_q, win_d, pick, idx;
    logic [2:0]         attr_q, attr_d;
    logic [1:0]         op_q, op_d;
    logic [13:0]        operand_q, operand_d;
    logic [4:0][13:0]   values_q, values_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               flag_q, flag_d, found, sat;
    logic [14:0]        cur, opd, res;
    logic [2:0]         attr_a [NUM_REQ];
    logic [1:0]         op_a   [NUM_REQ];
    logic [13:0]        opd_a  [NUM_REQ];

    logic [2:0]         frame_sync_q;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [4:0]         done_q, done_d;
    logic [3:0]         prog_q, prog_d;
    logic               use_ok_q, use_ok_d, tick, step, full;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            attr_a[i] = REQ_ATTR[i*3 +: 3];
            op_a[i]   = REQ_OP[i*2 +: 2];
            opd_a[i]  = REQ_OPERAND[i*14 +: 14];
        end
    end

    // First requester at or after the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!found && REQ_VALID[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        attr_d    = attr_q;
        op_d      = op_q;
        operand_d = operand_q;
        values_d  = values_q;
        ack_d     = '0;
        flag_d    = 1'b0;
        sat       = 1'b0;
        cur       = '0;
        res       = '0;
        opd       = {1'b0, operand_q};
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    win_d     = pick;
                    attr_d    = attr_a[pick];
                    op_d      = op_a[pick];
                    operand_d = opd_a[pick];
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                if (attr_q <= 3'd4) begin
                    cur = {1'b0, values_q[attr_q]};
                    case (op_q)
                        OP_ADD: begin
                            res = cur + opd;
                            if (res > MAX15) begin
                                res = MAX15;
                                sat = 1'b1;
                            end
                        end
                        OP_SUB: begin
                            if (cur >= opd) begin
                                res = cur - opd;
                            end else begin
                                res = '0;
                                sat = 1'b1;
                            end
                        end
                        OP_SET: begin
                            if (opd > MAX15) begin
                                res = MAX15;
                                sat = 1'b1;
                            end else begin
                                res = opd;
                            end
                        end
                        default: res = cur;
                    endcase
                    values_d[attr_q] = res[13:0];
                end else begin
                    sat = 1'b1;
                end
                ack_d[win_q] = 1'b1;
                flag_d       = sat;
                state_d      = S_DONE;
            end
            S_DONE: begin
                ptr_d   = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tick = frame_sync_q[1] & ~frame_sync_q[2];
    assign full = &done_q;

    // A consume on a full gauge overrides any step landing in the same cycle.
    always_comb begin
        div_d    = div_q;
        done_d   = done_q;
        prog_d   = prog_q;
        use_ok_d = 1'b0;
        step     = 1'b0;
        if (tick) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                step  = 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
        if (ENERGY_USE && full) begin
            done_d   = '0;
            prog_d   = '0;
            div_d    = '0;
            use_ok_d = 1'b1;
        end else if (step && !full) begin
            if (prog_q == 4'd15) begin
                done_d = done_q | (~done_q & (done_q + 5'd1));
                prog_d = '0;
            end else begin
                prog_d = prog_q + 4'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            win_q        <= '0;
            attr_q       <= '0;
            op_q         <= '0;
            operand_q    <= '0;
            values_q     <= INIT_VALUES;
            ack_q        <= '0;
            flag_q       <= 1'b0;
            frame_sync_q <= '0;
            div_q        <= '0;
            done_q       <= '0;
            prog_q       <= '0;
            use_ok_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            win_q        <= win_d;
            attr_q       <= attr_d;
            op_q         <= op_d;
            operand_q    <= operand_d;
            values_q     <= values_d;
            ack_q        <= ack_d;
            flag_q       <= flag_d;
            frame_sync_q <= {frame_sync_q[1:0], FRAME_CLK};
            div_q        <= div_d;
            done_q       <= done_d;
            prog_q       <= prog_d;
            use_ok_q     <= use_ok_d;
        end
    end

    assign REQ_ACK        = ack_q;
    assign REQ_FLAG       = flag_q;
    assign ENERGY_USE_OK  = use_ok_q;
    assign ValueArr       = values_q;
    assign EnergyDone     = done_q;
    assign EnergyProgress = prog_q;

endmodule

// File: tb/tb_attribute_update_scheduler.sv
// Scoreboard bench for attribute_update_scheduler: expected ACK/FLAG/values are
// queued at drive time from a behavioural model and checked when each ACK appears.
module tb_attribute_update_scheduler;

    localparam logic [69:0] INIT = {14'd0, 14'd0, 14'd10, 14'd10, 14'd1000};

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        FRAME_CLK = 1'b0;
    logic [2:0]  REQ_VALID = '0;
    logic [8:0]  REQ_ATTR;
    logic [5:0]  REQ_OP;
    logic [41:0] REQ_OPERAND;
    logic [2:0]  REQ_ACK;
    logic        REQ_FLAG;
    logic        ENERGY_USE = 1'b0;
    logic        ENERGY_USE_OK;
    logic [69:0] ValueArr;
    logic [4:0]  EnergyDone;
    logic [3:0]  EnergyProgress;

    logic [2:0]  t_attr [3];
    logic [1:0]  t_op   [3];
    logic [13:0] t_opd  [3];

    typedef struct {
        int          req;
        logic        flag;
        logic [69:0] vals;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   mv[5];
    int   total = 0;
    int   bad = 0;

    assign REQ_ATTR    = {t_attr[2], t_attr[1], t_attr[0]};
    assign REQ_OP      = {t_op[2], t_op[1], t_op[0]};
    assign REQ_OPERAND = {t_opd[2], t_opd[1], t_opd[0]};

    attribute_update_scheduler dut (
        .CLK(CLK), .RESET_N(RESET_N), .FRAME_CLK(FRAME_CLK),
        .REQ_VALID(REQ_VALID), .REQ_ATTR(REQ_ATTR), .REQ_OP(REQ_OP),
        .REQ_OPERAND(REQ_OPERAND), .REQ_ACK(REQ_ACK), .REQ_FLAG(REQ_FLAG),
        .ENERGY_USE(ENERGY_USE), .ENERGY_USE_OK(ENERGY_USE_OK),
        .ValueArr(ValueArr), .EnergyDone(EnergyDone), .EnergyProgress(EnergyProgress)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        mv[0] = 1000; mv[1] = 10; mv[2] = 10; mv[3] = 0; mv[4] = 0;
    endfunction

    function automatic logic model_apply(input int a, input int op, input int opd);
        logic f;
        int   s;
        f = 1'b0;
        if (a > 4) return 1'b1;
        s = mv[a];
        case (op)
            0: begin s = mv[a] + opd; if (s > 9999) begin s = 9999; f = 1'b1; end end
            1: begin if (mv[a] >= opd) s = mv[a] - opd; else begin s = 0; f = 1'b1; end end
            2: begin if (opd > 9999) begin s = 9999; f = 1'b1; end else s = opd; end
            default: s = mv[a];
        endcase
        mv[a] = s;
        return f;
    endfunction

    task automatic push_exp(input int r, input int a, input int op, input int opd);
        exp_t e;
        e.req  = r;
        e.flag = model_apply(a, op, opd);
        for (int k = 0; k < 5; k++) e.vals[k*14 +: 14] = 14'(mv[k]);
        sb.push_back(e);
    endtask

    task automatic set_req(input int r, input int a, input int op, input int opd);
        t_attr[r] = 3'(a);
        t_op[r]   = 2'(op);
        t_opd[r]  = 14'(opd);
    endtask

    // Drives one request from a negedge; lat = negedges until its ACK, -1 on timeout.
    task automatic do_req(input int r, input int a, input int op, input int opd, output int lat);
        set_req(r, a, op, opd);
        push_exp(r, a, op, opd);
        REQ_VALID[r] = 1'b1;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge CLK);
            if (REQ_ACK[r] === 1'b1) begin
                lat = c;
                break;
            end
        end
        REQ_VALID[r] = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic frame_edges(input int n);
        for (int i = 0; i < n; i++) begin
            FRAME_CLK = 1'b1;
            repeat (3) @(negedge CLK);
            FRAME_CLK = 1'b0;
            repeat (3) @(negedge CLK);
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (RESET_N === 1'b1 && REQ_ACK !== 3'b000) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_ack got=%b want=none", REQ_ACK);
                end else begin
                    mon_e = sb.pop_front();
                    if (REQ_ACK !== (3'b001 << mon_e.req)) begin
                        bad++;
                        $display("FAIL ack_onehot got=%b want=%b", REQ_ACK, 3'b001 << mon_e.req);
                    end
                    total++;
                    if (REQ_FLAG !== mon_e.flag) begin
                        bad++;
                        $display("FAIL req_flag req=%0d got=%b want=%b", mon_e.req, REQ_FLAG, mon_e.flag);
                    end
                    total++;
                    if (ValueArr !== mon_e.vals) begin
                        bad++;
                        $display("FAIL value_arr got=%h want=%h", ValueArr, mon_e.vals);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        for (int r = 0; r < 3; r++) set_req(r, 0, 3, 0);
        model_reset();
        RESET_N = 1'b0;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        total++; if (ValueArr !== INIT) begin bad++; $display("FAIL reset_values got=%h want=%h", ValueArr, INIT); end
        total++; if (EnergyDone !== 5'd0) begin bad++; $display("FAIL reset_done got=%b want=0", EnergyDone); end
        total++; if (EnergyProgress !== 4'd0) begin bad++; $display("FAIL reset_prog got=%0d want=0", EnergyProgress); end
        total++; if (REQ_ACK !== 3'd0) begin bad++; $display("FAIL reset_ack got=%b want=000", REQ_ACK); end
        total++; if (REQ_FLAG !== 1'b0) begin bad++; $display("FAIL reset_flag got=%b want=0", REQ_FLAG); end
        total++; if (ENERGY_USE_OK !== 1'b0) begin bad++; $display("FAIL reset_use_ok got=%b want=0", ENERGY_USE_OK); end
    endtask

    task automatic test_add_set();
        int lat;
        do_req(0, 0, 0, 500, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL add_latency got=%0d want=2", lat); end
        do_req(0, 0, 0, 9000, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL add_sat_latency got=%0d want=2", lat); end
        do_req(2, 1, 2, 12000, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL set_clamp_latency got=%0d want=2", lat); end
        do_req(2, 2, 2, 50, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL set_latency got=%0d want=2", lat); end
        do_req(1, 2, 0, 9949, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL add_exact_max_latency got=%0d want=2", lat); end
        do_req(0, 0, 3, 5, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL nop_latency got=%0d want=2", lat); end
        total++; if (sb.size() !== 0) begin bad++; $display("FAIL add_pending got=%0d want=0", sb.size()); end
    endtask

    task automatic test_sub_badidx();
        int lat;
        do_req(1, 3, 1, 5, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL sub_under_latency got=%0d want=2", lat); end
        do_req(1, 6, 0, 1, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL bad_idx_latency got=%0d want=2", lat); end
        do_req(1, 0, 1, 999, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL sub_latency got=%0d want=2", lat); end
        do_req(1, 4, 1, 0, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL sub_zero_latency got=%0d want=2", lat); end
        total++; if (sb.size() !== 0) begin bad++; $display("FAIL sub_pending got=%0d want=0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        int seen, last, now;
        RESET_N = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        model_reset();
        @(negedge CLK);
        set_req(0, 4, 0, 7);
        set_req(1, 3, 2, 123);
        set_req(2, 2, 1, 3);
        push_exp(0, 4, 0, 7);
        push_exp(1, 3, 2, 123);
        push_exp(2, 2, 1, 3);
        push_exp(0, 4, 0, 7);
        REQ_VALID = 3'b111;
        seen = 0;
        last = 0;
        for (int c = 1; c <= 40 && seen < 4; c++) begin
            @(negedge CLK);
            if (REQ_ACK !== 3'b000) begin
                now = c;
                total++;
                if (now - last !== ((seen == 0) ? 2 : 3)) begin
                    bad++;
                    $display("FAIL b2b_spacing ack#%0d got=%0d want=%0d", seen, now - last, (seen == 0) ? 2 : 3);
                end
                last = now;
                seen++;
            end
        end
        REQ_VALID = 3'b000;
        total++; if (seen !== 4) begin bad++; $display("FAIL b2b_ack_count got=%0d want=4", seen); end
        repeat (6) @(negedge CLK);
        total++; if (sb.size() !== 0) begin bad++; $display("FAIL b2b_pending got=%0d want=0", sb.size()); end
    endtask

    task automatic test_energy();
        frame_edges(8);
        total++; if (EnergyProgress !== 4'd1 || EnergyDone !== 5'd0) begin bad++; $display("FAIL first_step got=%b/%0d want=00000/1", EnergyDone, EnergyProgress); end
        frame_edges(119);
        total++; if (EnergyProgress !== 4'd15 || EnergyDone !== 5'd0) begin bad++; $display("FAIL edge127 got=%b/%0d want=00000/15", EnergyDone, EnergyProgress); end
        frame_edges(1);
        total++; if (EnergyProgress !== 4'd0 || EnergyDone !== 5'b00001) begin bad++; $display("FAIL edge128 got=%b/%0d want=00001/0", EnergyDone, EnergyProgress); end
        ENERGY_USE = 1'b1;
        @(negedge CLK);
        ENERGY_USE = 1'b0;
        total++; if (ENERGY_USE_OK !== 1'b0) begin bad++; $display("FAIL use_partial_ok got=%b want=0", ENERGY_USE_OK); end
        @(negedge CLK);
        total++; if (ENERGY_USE_OK !== 1'b0 || EnergyDone !== 5'b00001 || EnergyProgress !== 4'd0) begin bad++; $display("FAIL use_partial_state got=%b/%b/%0d want=0/00001/0", ENERGY_USE_OK, EnergyDone, EnergyProgress); end
        frame_edges(512);
        total++; if (EnergyProgress !== 4'd0 || EnergyDone !== 5'b11111) begin bad++; $display("FAIL edge640 got=%b/%0d want=11111/0", EnergyDone, EnergyProgress); end
        frame_edges(16);
        total++; if (EnergyProgress !== 4'd0 || EnergyDone !== 5'b11111) begin bad++; $display("FAIL full_hold got=%b/%0d want=11111/0", EnergyDone, EnergyProgress); end
        ENERGY_USE = 1'b1;
        @(negedge CLK);
        ENERGY_USE = 1'b0;
        total++; if (ENERGY_USE_OK !== 1'b1) begin bad++; $display("FAIL use_full_ok got=%b want=1", ENERGY_USE_OK); end
        total++; if (EnergyDone !== 5'd0 || EnergyProgress !== 4'd0) begin bad++; $display("FAIL use_full_clear got=%b/%0d want=00000/0", EnergyDone, EnergyProgress); end
        @(negedge CLK);
        total++; if (ENERGY_USE_OK !== 1'b0) begin bad++; $display("FAIL use_ok_pulse got=%b want=0", ENERGY_USE_OK); end
    endtask

    task automatic test_reset_mid();
        logic acked;
        set_req(2, 0, 2, 1234);
        REQ_VALID[2] = 1'b1;
        @(negedge CLK);
        RESET_N = 1'b0;
        REQ_VALID[2] = 1'b0;
        #1;
        total++; if (ValueArr !== INIT) begin bad++; $display("FAIL midreset_values got=%h want=%h", ValueArr, INIT); end
        acked = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            if (REQ_ACK !== 3'b000) acked = 1'b1;
        end
        RESET_N = 1'b1;
        model_reset();
        repeat (6) begin
            @(negedge CLK);
            if (REQ_ACK !== 3'b000) acked = 1'b1;
        end
        total++; if (acked !== 1'b0) begin bad++; $display("FAIL midreset_ack got=1 want=0"); end
        total++; if (ValueArr !== INIT) begin bad++; $display("FAIL midreset_after got=%h want=%h", ValueArr, INIT); end
    endtask

    initial begin
        test_reset();
        test_add_set();
        test_sub_badidx();
        test_back_to_back();
        test_energy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
